dmem_bridge: RTL and testbench

Data-memory bridge downstream of the single-cycle datapath. It turns the datapath's combinational load/store (aluout address, writedata, memwrite) into a req/ack bus transaction, and holds the CPU with `stall` while the bus is busy. It also decodes a small memory-mapped I/O window (LED register, cycle counter) answered without a bus access, and flags misaligned or timed-out accesses.

---
 rtl/dmem_bridge.sv | 165 ++++++++++++++++
 tb/tb_dmem_bridge.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bridge.sv
// Data-memory bridge: converts the datapath's combinational load/store into a
// registered req/ack bus transaction and serves a two-register MMIO window.
module dmem_bridge #(
    parameter int unsigned TIMEOUT   = 16,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
    parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic [31:0] led,
    output logic        err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int unsigned    TW    = $clog2(TIMEOUT);
    localparam logic [TW-1:0]  TLAST = TW'(TIMEOUT - 1);

    logic [1:0]    state;
    logic [1:0]    state_next;
    logic [TW-1:0] tout_cnt;
    logic [31:0]   rdata_q;
    logic [31:0]   cycle_cnt;
    logic          timed_out;

    logic misaligned;
    logic hit_led;
    logic hit_cnt;
    logic is_mmio;
    logic is_ram;
    logic in_idle;
    logic start_ram;
    logic led_write;
    logic bad_access;

    assign misaligned = (addr[1:0] != 2'b00);
    assign hit_led    = (addr == MMIO_BASE);
    assign hit_cnt    = (addr == (MMIO_BASE + 32'd4));
    assign is_mmio    = !misaligned && (hit_led || hit_cnt);
    assign is_ram     = !misaligned && !is_mmio;

    assign in_idle    = (state == IDLE);
    assign start_ram  = in_idle && mem_en && is_ram;
    assign led_write  = in_idle && mem_en && memwrite && is_mmio && hit_led;
    assign bad_access = in_idle && mem_en && misaligned;

    // An ack in the last REQ cycle takes priority over the timeout abort.
    always_comb begin
        state_next = state;
        timed_out  = 1'b0;
        case (state)
            IDLE: begin
                if (start_ram) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (bus_ack) begin
                    state_next = DONE;
                end else if (tout_cnt == TLAST) begin
                    state_next = DONE;
                    timed_out  = 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            bus_req <= 1'b0;
        end else begin
            state   <= state_next;
            bus_req <= (state_next == REQ);
        end
    end

    // Bus address/data/direction are captured once and held for the whole request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_addr  <= 32'h0;
            bus_wdata <= 32'h0;
            bus_we    <= 1'b0;
            tout_cnt  <= '0;
        end else if (start_ram) begin
            bus_addr  <= {addr[31:2], 2'b00};
            bus_wdata <= writedata;
            bus_we    <= memwrite;
            tout_cnt  <= '0;
        end else if (state == REQ && !bus_ack) begin
            tout_cnt  <= tout_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= 32'h0;
        end else if (state == REQ) begin
            if (bus_ack) begin
                if (!bus_we) begin
                    rdata_q <= bus_rdata;
                end
            end else if (timed_out) begin
                rdata_q <= ERR_DATA;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (bad_access || timed_out) begin
            err <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led <= 32'h0;
        end else if (led_write) begin
            led <= writedata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt <= 32'h0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    // MMIO loads answer in the IDLE cycle; RAM loads present their data in DONE.
    always_comb begin
        readdata = 32'h0;
        case (state)
            IDLE: begin
                if (mem_en && !memwrite && is_mmio) begin
                    readdata = hit_led ? led : cycle_cnt;
                end
            end
            DONE:    readdata = rdata_q;
            default: readdata = 32'h0;
        endcase
    end

    assign stall = !rst && (start_ram || state == REQ);

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: directed access table, hand-written reset,
// counter and wrap sequences, then random accesses against a transaction-level model.
module tb_dmem_bridge;

    localparam int          T    = 4;
    localparam logic [31:0] BASE = 32'hFFFF_0000;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic        clk       = 1'b0;
    logic        rst       = 1'b0;
    logic        mem_en    = 1'b0;
    logic        memwrite  = 1'b0;
    logic        bus_ack   = 1'b0;
    logic [31:0] addr      = 32'h0;
    logic [31:0] writedata = 32'h0;
    logic [31:0] bus_rdata = 32'h0;
    logic [31:0] readdata;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] led;
    logic        stall;
    logic        bus_req;
    logic        bus_we;
    logic        err;

    int errors = 0;
    int checks = 0;
    int edges  = 0;

    logic [31:0] m_led;
    logic [31:0] m_rq;
    logic [31:0] cnt_ref_val;
    logic        m_err;
    int          cnt_ref_edge;

    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [31:0] wd;
        int          ack_at;
        logic [31:0] rd;
        logic [31:0] e_rd;
        int          e_stall;
        int          e_req;
        logic        e_err;
        logic [31:0] e_led;
    } vec_t;

    vec_t vecs[12];

    dmem_bridge #(
        .TIMEOUT   (T),
        .MMIO_BASE (BASE),
        .ERR_DATA  (ERRD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_en    (mem_en),
        .memwrite  (memwrite),
        .addr      (addr),
        .writedata (writedata),
        .readdata  (readdata),
        .stall     (stall),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .led       (led),
        .err       (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edges++;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " readdata"},  readdata,         32'h0);
        checkOutput({tag, " stall"},     32'(stall),       32'h0);
        checkOutput({tag, " bus_req"},   32'(bus_req),     32'h0);
        checkOutput({tag, " bus_we"},    32'(bus_we),      32'h0);
        checkOutput({tag, " bus_addr"},  bus_addr,         32'h0);
        checkOutput({tag, " bus_wdata"}, bus_wdata,        32'h0);
        checkOutput({tag, " led"},       led,              32'h0);
        checkOutput({tag, " err"},       32'(err),         32'h0);
    endtask

    task automatic modelReset();
        m_led        = 32'h0;
        m_rq         = 32'h0;
        m_err        = 1'b0;
        cnt_ref_val  = 32'h0;
        cnt_ref_edge = edges;
    endtask

    // Counter value = value at a reference point plus clock edges elapsed since then.
    function automatic logic [31:0] cntModel(input int samp);
        return cnt_ref_val + 32'(samp - cnt_ref_edge);
    endfunction

    task automatic resetDut();
        @(negedge clk);
        rst     = 1'b1;
        mem_en  = 1'b0;
        bus_ack = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        modelReset();
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            mem_en   = 1'b0;
            memwrite = 1'($urandom_range(0, 1));
            addr     = BASE;
            bus_ack  = 1'b0;
            #1;
            checkOutput("idle stall",    32'(stall),   32'h0);
            checkOutput("idle bus_req",  32'(bus_req), 32'h0);
            checkOutput("idle readdata", readdata,     32'h0);
        end
    endtask

    // Acts as CPU and bus slave for one instruction; returns what was observed.
    task automatic applyStimulus(input logic we, input logic [31:0] a, input logic [31:0] wd,
                                 input int ack_at, input logic [31:0] rd,
                                 output logic [31:0] got_rd, output int n_stall, output int n_req,
                                 output logic bus_ok, output logic finished, output int samp_edge);
        int reqn;
        reqn      = 0;
        n_stall   = 0;
        bus_ok    = 1'b1;
        got_rd    = 32'h0;
        finished  = 1'b0;
        samp_edge = 0;
        for (int cyc = 0; cyc < T + 6; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                mem_en    = 1'b1;
                memwrite  = we;
                addr      = a;
                writedata = wd;
            end
            if (bus_req) begin
                reqn++;
                bus_ack   = (reqn == ack_at);
                bus_rdata = bus_ack ? rd : $urandom;
                if (bus_addr !== {a[31:2], 2'b00} || bus_we !== we || bus_wdata !== wd) begin
                    bus_ok = 1'b0;
                end
            end else begin
                bus_ack   = ($urandom_range(0, 3) == 0);
                bus_rdata = $urandom;
            end
            #1;
            if (stall) begin
                n_stall++;
            end else begin
                got_rd    = readdata;
                samp_edge = edges;
                finished  = 1'b1;
                break;
            end
        end
        n_req = reqn;
        @(posedge clk);
        #1;
    endtask

    // Transaction-level expectation: classification by address, then outcome by ack timing.
    task automatic modelAccess(input logic we, input logic [31:0] a, input logic [31:0] wd,
                               input int ack_at, input logic [31:0] rd, input int samp,
                               output logic [31:0] e_rd, output int e_stall, output int e_req);
        e_rd    = 32'h0;
        e_stall = 0;
        e_req   = 0;
        if (a[1:0] != 2'b00) begin
            m_err = 1'b1;
        end else if (a == BASE || a == BASE + 32'd4) begin
            if (!we) begin
                e_rd = (a == BASE) ? m_led : cntModel(samp);
            end else if (a == BASE) begin
                m_led = wd;
            end
        end else begin
            if (ack_at >= 1 && ack_at <= T) begin
                e_req = ack_at;
                if (!we) m_rq = rd;
            end else begin
                e_req = T;
                m_rq  = ERRD;
                m_err = 1'b1;
            end
            e_stall = e_req + 1;
            e_rd    = m_rq;
        end
    endtask

    initial begin
        logic [31:0] g_rd, e_rd, c1, c2, tmp, a, wd, rd;
        int          n_st, n_rq, s_e, s_e1, e_st, e_rq, kind, ack_at;
        logic        ok, fin, we;

        //          we    addr           wdata          ack rdata          exp rdata      st rq err   led
        vecs[0]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 3, 32'h1234_5678, 32'h1234_5678, 4, 3, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 32'h0000_0020, 32'hCAFE_0001, 1, 32'h5A5A_5A5A, 32'h1234_5678, 2, 1, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 32'hFFFF_0000, 32'h0000_00A5, 0, 32'h0,         32'h0,         0, 0, 1'b0, 32'hA5};
        vecs[3]  = '{1'b0, 32'hFFFF_0000, 32'h0,         0, 32'h0,         32'h0000_00A5, 0, 0, 1'b0, 32'hA5};
        vecs[4]  = '{1'b1, 32'hFFFF_0004, 32'h0000_0777, 0, 32'h0,         32'h0,         0, 0, 1'b0, 32'hA5};
        vecs[5]  = '{1'b0, 32'hFFFF_0000, 32'h0,         0, 32'h0,         32'h0000_00A5, 0, 0, 1'b0, 32'hA5};
        vecs[6]  = '{1'b0, 32'hFFFF_0008, 32'h0,         1, 32'h0000_0055, 32'h0000_0055, 2, 1, 1'b0, 32'hA5};
        vecs[7]  = '{1'b0, 32'h0000_0044, 32'h0,         4, 32'hAAAA_5555, 32'hAAAA_5555, 5, 4, 1'b0, 32'hA5};
        vecs[8]  = '{1'b0, 32'h0000_0100, 32'h0,         0, 32'h0,         32'hDEAD_BEEF, 5, 4, 1'b1, 32'hA5};
        vecs[9]  = '{1'b0, 32'h0000_0104, 32'h0,         2, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 3, 2, 1'b1, 32'hA5};
        vecs[10] = '{1'b1, 32'h0000_0200, 32'h0000_1111, 0, 32'h0,         32'hDEAD_BEEF, 5, 4, 1'b1, 32'hA5};
        vecs[11] = '{1'b0, 32'h0000_0300, 32'h0,         1, 32'h8000_0001, 32'h8000_0001, 2, 1, 1'b1, 32'hA5};

        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkResetOutputs("reset");
        rst = 1'b0;
        modelReset();

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].we, vecs[i].a, vecs[i].wd, vecs[i].ack_at, vecs[i].rd,
                          g_rd, n_st, n_rq, ok, fin, s_e);
            checkOutput($sformatf("vec%0d done", i),     32'(fin),  32'h1);
            checkOutput($sformatf("vec%0d readdata", i), g_rd,      vecs[i].e_rd);
            checkOutput($sformatf("vec%0d stalls", i),   32'(n_st), 32'(vecs[i].e_stall));
            checkOutput($sformatf("vec%0d req", i),      32'(n_rq), 32'(vecs[i].e_req));
            checkOutput($sformatf("vec%0d err", i),      32'(err),  32'(vecs[i].e_err));
            checkOutput($sformatf("vec%0d led", i),      led,       vecs[i].e_led);
            if (vecs[i].e_req > 0) begin
                checkOutput($sformatf("vec%0d bus stable", i), 32'(ok), 32'h1);
            end
        end

        // Inputs on the bus side while mem_en is low must not touch the LED register.
        idleCycles(2);
        checkOutput("idle led kept", led, 32'hA5);

        applyStimulus(1'b0, BASE + 32'd4, 32'h0, 0, 32'h0, c1, n_st, n_rq, ok, fin, s_e1);
        checkOutput("cnt1 value", c1, cntModel(s_e1));
        idleCycles(7);
        applyStimulus(1'b0, BASE + 32'd4, 32'h0, 0, 32'h0, c2, n_st, n_rq, ok, fin, s_e);
        checkOutput("cnt2 value", c2, cntModel(s_e));
        checkOutput("cnt delta", c2 - c1, 32'(s_e - s_e1));

        @(negedge clk);
        mem_en   = 1'b1;
        memwrite = 1'b0;
        addr     = BASE + 32'd4;
        bus_ack  = 1'b0;
        force dut.cycle_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_cnt;
        cnt_ref_val  = 32'hFFFF_FFFF;
        cnt_ref_edge = edges;
        #1;
        checkOutput("wrap before", readdata, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        checkOutput("wrap after", readdata, 32'h0);

        @(negedge clk);
        mem_en    = 1'b1;
        memwrite  = 1'b0;
        addr      = 32'h0000_0080;
        writedata = 32'h0000_0BAD;
        bus_ack   = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("midreq bus_req", 32'(bus_req), 32'h1);
        rst = 1'b1;
        #1;
        checkResetOutputs("midreq");
        mem_en = 1'b0;
        @(negedge clk);
        rst       = 1'b0;
        modelReset();
        bus_ack   = 1'b1;
        bus_rdata = 32'h9999_9999;
        idleCycles(3);
        applyStimulus(1'b1, 32'h0000_0040, 32'h0000_4444, 1, 32'h7777_7777, g_rd, n_st, n_rq, ok, fin, s_e);
        checkOutput("postreset store readdata", g_rd, 32'h0);
        checkOutput("postreset store stalls", 32'(n_st), 32'd2);

        resetDut();
        applyStimulus(1'b1, 32'h0000_0013, 32'h0000_00EE, 1, 32'h0, g_rd, n_st, n_rq, ok, fin, s_e);
        checkOutput("misaligned readdata", g_rd,      32'h0);
        checkOutput("misaligned stalls",   32'(n_st), 32'h0);
        checkOutput("misaligned req",      32'(n_rq), 32'h0);
        checkOutput("misaligned err",      32'(err),  32'h1);
        applyStimulus(1'b1, BASE + 32'd1, 32'h0000_0099, 1, 32'h0, g_rd, n_st, n_rq, ok, fin, s_e);
        checkOutput("misaligned mmio led", led, 32'h0);

        resetDut();
        for (int i = 0; i < 60; i++) begin
            kind   = $urandom_range(0, 9);
            tmp    = $urandom;
            we     = 1'($urandom_range(0, 1));
            wd     = $urandom;
            rd     = $urandom;
            ack_at = $urandom_range(0, T + 1);
            if (kind == 9) begin
                idleCycles($urandom_range(1, 3));
                continue;
            end
            if (kind <= 4) begin
                a = {tmp[31:2], 2'b00};
            end else if (kind <= 7) begin
                a = tmp[0] ? BASE + 32'd4 : BASE;
            end else begin
                a = {tmp[31:2], 2'b00} | 32'($urandom_range(1, 3));
            end
            applyStimulus(we, a, wd, ack_at, rd, g_rd, n_st, n_rq, ok, fin, s_e);
            modelAccess(we, a, wd, ack_at, rd, s_e, e_rd, e_st, e_rq);
            checkOutput($sformatf("rnd%0d done", i),     32'(fin),  32'h1);
            checkOutput($sformatf("rnd%0d readdata", i), g_rd,      e_rd);
            checkOutput($sformatf("rnd%0d stalls", i),   32'(n_st), 32'(e_st));
            checkOutput($sformatf("rnd%0d req", i),      32'(n_rq), 32'(e_rq));
            checkOutput($sformatf("rnd%0d err", i),      32'(err),  32'(m_err));
            checkOutput($sformatf("rnd%0d led", i),      led,       m_led);
            if (e_rq > 0) begin
                checkOutput($sformatf("rnd%0d bus stable", i), 32'(ok), 32'h1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
